// File: rtl/uop_sequencer_if.sv
// uop_sequencer_if: control, uop ROM and datapath issue signals of the uop sequencer
interface uop_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 20
);
  logic              ena;
  logic              rdy;
  logic              err;
  logic              flag;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [3:0]        uop_opcode;
  logic [4:0]        uop_src1;
  logic [4:0]        uop_src2;
  logic [3:0]        uop_dst;
  logic              uop_start;
  logic              uop_done;
  modport master (
    input  ena, flag, rom_data, uop_done,
    output rdy, err, rom_addr, uop_opcode, uop_src1, uop_src2, uop_dst, uop_start
  );
  modport slave (
    output ena, flag, rom_data, uop_done,
    input  rdy, err, rom_addr, uop_opcode, uop_src1, uop_src2, uop_dst, uop_start
  );
endinterface

// File: rtl/uop_sequencer.sv
// uop_sequencer: walks the uop ROM, decodes words and issues them to the datapath; UOP_SEQ_WATCHDOG_EN adds a WAIT watchdog
module uop_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int WORD_W   = 20,
  parameter int WDOG_MAX = 255
) (
  input logic              clk,
  input logic              rst_n,
  uop_sequencer_if.master  bus
);
  localparam logic [3:0] OPCODE_RDY = 4'd0;
  typedef enum logic [1:0] {IDLE, FETCH, DECODE, WAIT} state_t;
  state_t            state, state_n;
  logic              rdy_n, err_n, start_n, adv, cond, wdog_hit;
  logic [ADDR_W-1:0] addr_n;
  logic [17:0]       fields_n;
  logic [1:0]        exec;
  assign exec = bus.rom_data[1:0];
  assign cond = exec == 2'b00 || (exec == 2'b01 && bus.flag) || (exec == 2'b10 && !bus.flag);
`ifdef UOP_SEQ_WATCHDOG_EN
  logic [7:0] wdog, wdog_n;
  assign wdog_hit = wdog == 8'(WDOG_MAX - 1);
  // WAIT-cycle counter, cleared when a uop is issued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog <= '0;
    else wdog <= wdog_n;
`else
  assign wdog_hit = 1'b0;
`endif
  // next state and next values of every registered output
  always_comb begin
    state_n  = state;
    rdy_n    = bus.rdy;
    err_n    = bus.err;
    addr_n   = bus.rom_addr;
    start_n  = 1'b0;
    fields_n = {bus.uop_opcode, bus.uop_src1, bus.uop_src2, bus.uop_dst};
    adv      = 1'b0;
`ifdef UOP_SEQ_WATCHDOG_EN
    wdog_n   = state == WAIT ? wdog + 8'd1 : wdog;
`endif
    case (state)
      IDLE: if (bus.ena) begin
        addr_n  = '0;
        rdy_n   = 1'b0;
        err_n   = 1'b0;
        state_n = FETCH;
      end
      FETCH: state_n = DECODE;
      DECODE:
        if (bus.rom_data[19:16] == OPCODE_RDY) begin
          rdy_n   = 1'b1;
          state_n = IDLE;
        end else if (!cond) adv = 1'b1;
        else begin
          fields_n = bus.rom_data[WORD_W-1:2];
          start_n  = 1'b1;
          state_n  = WAIT;
`ifdef UOP_SEQ_WATCHDOG_EN
          wdog_n   = '0;
`endif
        end
      WAIT:
        if (bus.uop_done) adv = 1'b1;
        else if (wdog_hit) begin
          err_n   = 1'b1;
          rdy_n   = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    if (adv) begin
      if (&bus.rom_addr) begin
        err_n   = 1'b1;
        rdy_n   = 1'b1;
        state_n = IDLE;
      end else begin
        addr_n  = bus.rom_addr + 1'b1;
        state_n = FETCH;
      end
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      bus.rdy       <= 1'b1;
      bus.err       <= 1'b0;
      bus.rom_addr  <= '0;
      bus.uop_start <= 1'b0;
      {bus.uop_opcode, bus.uop_src1, bus.uop_src2, bus.uop_dst} <= '0;
    end else begin
      state         <= state_n;
      bus.rdy       <= rdy_n;
      bus.err       <= err_n;
      bus.rom_addr  <= addr_n;
      bus.uop_start <= start_n;
      {bus.uop_opcode, bus.uop_src1, bus.uop_src2, bus.uop_dst} <= fields_n;
    end
endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: randomized and directed programs checked against a program-walk model
module tb_uop_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uop_sequencer_if #(.ADDR_W(6), .WORD_W(20)) bus ();
  uop_sequencer #(.ADDR_W(6), .WORD_W(20), .WDOG_MAX(255)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [19:0] mem [64];
  always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];
  int checks = 0, failures = 0;
  int fixed_lat = 1;
  bit never_done = 0, noise = 0;
  int lat_q[$];
  int dst_log[$];
  bit pending;
  int cnt;
  logic [17:0] lf;
  logic [19:0] exp_w[$];
  int exp_a[$];
  int exp_visit, exp_fin;
  bit exp_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mkw(input int op, input int s1, input int s2, input int d, input int e);
    return {4'(op), 5'(s1), 5'(s2), 4'(d), 2'(e)};
  endfunction

  // datapath stand-in: done after a chosen latency, random noise while nothing is outstanding
  initial begin
    pending = 0;
    cnt = 0;
    bus.uop_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pending = 0;
        bus.uop_done = 1'b0;
      end else begin
        if (pending && bus.uop_done) pending = 0;
        if (bus.uop_start) begin
          pending = 1;
          cnt = fixed_lat < 0 ? int'($urandom_range(0, 3)) : fixed_lat;
          lat_q.push_back(cnt);
        end else if (pending && cnt > 0) cnt--;
        bus.uop_done = pending ? (!never_done && cnt == 0) : (noise && $urandom_range(0, 1) == 1);
      end
    end
  end

  // walk the program: which words issue, where it stops, whether it overruns
  task automatic build_model(input bit f);
    exp_w.delete();
    exp_a.delete();
    exp_visit = 0;
    exp_ovr = 0;
    for (int a = 0; a < 64; a++) begin
      logic [19:0] w;
      w = mem[a];
      exp_visit++;
      if (w[19:16] == 4'd0) begin
        exp_fin = a;
        return;
      end
      if (w[1:0] == 2'd0 || (w[1:0] == 2'd1 && f) || (w[1:0] == 2'd2 && !f)) begin
        exp_w.push_back(w);
        exp_a.push_back(a);
      end
    end
    exp_ovr = 1;
    exp_fin = 63;
  endtask

  task automatic run(input int maxc, input bit check_end, output int cycles, output int nstb, output bit tout);
    int n_exp, suml;
    build_model(bus.flag);
    n_exp = exp_w.size();
    lat_q.delete();
    dst_log.delete();
    nstb = 0;
    cycles = 0;
    tout = 0;
    @(negedge clk);
    bus.ena = 1'b1;
    @(posedge clk);
    #1;
    forever begin
      bus.ena = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      cycles++;
      if (bus.uop_start) begin
        nstb++;
        dst_log.push_back(int'(bus.uop_dst));
        if (exp_w.size() == 0) chk("unexpected_strobe", bus.uop_start, 0);
        else begin
          lf = exp_w[0][19:2];
          chk("strobe_addr", bus.rom_addr, exp_a[0]);
          exp_w.pop_front();
          exp_a.pop_front();
        end
      end
      chk("fields", {bus.uop_opcode, bus.uop_src1, bus.uop_src2, bus.uop_dst}, lf);
      if (bus.rdy) break;
      if (cycles >= maxc) begin
        tout = 1;
        break;
      end
    end
    bus.ena = 1'b0;
    if (check_end) begin
      chk("timeout", tout, 0);
      suml = 0;
      foreach (lat_q[i]) suml += lat_q[i];
      chk("cycles", cycles, 2 * exp_visit + n_exp + suml);
      chk("strobes", nstb, n_exp);
      chk("err", bus.err, exp_ovr);
      chk("fin_addr", bus.rom_addr, exp_fin);
      chk("rdy", bus.rdy, 1);
    end
  endtask

  task automatic load_init();
    foreach (mem[i]) mem[i] = 20'd0;
    mem[0] = mkw(1, 1, 0, 1, 0);
    mem[1] = mkw(1, 1, 0, 2, 0);
    mem[2] = mkw(1, 0, 0, 3, 0);
    mem[3] = mkw(0, 0, 0, 0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, nst;
    bit tout;
    bus.ena = 1'b0;
    bus.flag = 1'b0;
    lf = '0;
    load_init();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_rdy", bus.rdy, 1);
    chk("reset_err", bus.err, 0);
    chk("reset_addr", bus.rom_addr, 0);
    chk("reset_start", bus.uop_start, 0);
    chk("reset_fields", {bus.uop_opcode, bus.uop_src1, bus.uop_src2, bus.uop_dst}, 0);

    run(500, 1, cyc, nst, tout);
    chk("init_cycles_lit", cyc, 14);
    chk("init_strobes_lit", nst, 3);
    chk("init_dst0", dst_log.size() > 0 ? dst_log[0] : -1, 1);
    chk("init_dst1", dst_log.size() > 1 ? dst_log[1] : -1, 2);
    chk("init_dst2", dst_log.size() > 2 ? dst_log[2] : -1, 3);

    mem[1] = mkw(5, 17, 9, 6, 1);
    bus.flag = 1'b0;
    run(500, 1, cyc, nst, tout);
    chk("skip_cycles_lit", cyc, 12);
    chk("skip_strobes_lit", nst, 2);
    bus.flag = 1'b1;
    run(500, 1, cyc, nst, tout);
    chk("flag_cycles_lit", cyc, 14);
    chk("flag_dst1_lit", dst_log.size() > 1 ? dst_log[1] : -1, 6);

    foreach (mem[i]) mem[i] = mkw(2 + i % 14, i % 32, (i * 7) % 32, i % 16, 0);
    run(1000, 1, cyc, nst, tout);
    chk("ovr_strobes_lit", nst, 64);
    chk("ovr_cycles_lit", cyc, 256);
    chk("ovr_err_lit", bus.err, 1);
    chk("ovr_addr_lit", bus.rom_addr, 63);

    fixed_lat = -1;
    noise = 1;
    for (int r = 0; r < 30; r++) begin
      foreach (mem[i]) mem[i] = {4'($urandom_range(1, 15)), 16'($urandom)};
      if ($urandom_range(0, 4) != 0) mem[$urandom_range(0, 63)][19:16] = 4'd0;
      bus.flag = 1'($urandom_range(0, 1));
      run(2000, 1, cyc, nst, tout);
    end
    noise = 0;
    fixed_lat = 1;

    load_init();
    never_done = 1;
    @(negedge clk);
    bus.ena = 1'b1;
    @(posedge clk);
    #1;
    bus.ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_start", bus.uop_start, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdy", bus.rdy, 1);
    chk("async_rst_start", bus.uop_start, 0);
    chk("async_rst_addr", bus.rom_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    never_done = 0;
    lf = '0;
    run(500, 1, cyc, nst, tout);
    chk("restart_cycles_lit", cyc, 14);

    load_init();
    never_done = 1;
`ifdef UOP_SEQ_WATCHDOG_EN
    run(2000, 0, cyc, nst, tout);
    chk("wdog_timeout", tout, 0);
    chk("wdog_cycles", cyc, 257);
    chk("wdog_err", bus.err, 1);
    chk("wdog_rdy", bus.rdy, 1);
`else
    run(1000, 0, cyc, nst, tout);
    chk("hang_busy", tout, 1);
    chk("hang_rdy", bus.rdy, 0);
    chk("hang_strobes", nst, 1);
`endif
    never_done = 0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("final_rdy", bus.rdy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
